perf_latency_gen: RTL

PERF_LATENCY_GEN -- requirements
Module: perf_latency_gen

---
 rtl/perf_latency_gen.sv | 93 +++++++++
 1 files changed

// File: rtl/perf_latency_gen.sv
// Latency generator: replays each accepted request as a response a programmed
// number of cycles later, strictly in acceptance order.
module perf_latency_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_en_i,
  input  logic [CNT_WIDTH-1:0]    cfg_latency_i,
  input  logic                    clear_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [DATA_WIDTH-1:0]   req_data_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic [$clog2(DEPTH):0]  usage_o,
  output logic                    overdue_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] USE_ONE  = 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CNT_WIDTH-1:0]  remaining;
  } entry_t;

  entry_t            entries [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    usage;
  logic              push;
  logic              pop;
  logic              head_due;
  logic [CNT_WIDTH-1:0] load_val;

  // Full is judged on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign req_ready_o = cfg_en_i && !clear_i && (usage < FULL_CNT);
  assign push        = req_valid_i && req_ready_o;

  assign head_due    = (entries[rd_ptr].remaining == '0);
  assign rsp_valid_o = (usage != '0) && head_due;
  assign pop         = rsp_valid_o && rsp_ready_i && !clear_i;
  assign overdue_o   = rsp_valid_o && !rsp_ready_i;

  // NOTE: the entry array has no reset; data is masked here instead, which
  // keeps the storage a plain register file while still reading 0 when idle.
  assign rsp_data_o  = rsp_valid_o ? entries[rd_ptr].data : '0;
  assign usage_o     = usage;

  // max(L,1)-1: latencies 0 and 1 both become due in the next cycle.
  assign load_val = (cfg_latency_i == '0) ? '0 : cfg_latency_i - CNT_WIDTH'(1);

  // Every slot counts down each cycle; stale slots are harmless because a
  // push always overwrites the countdown.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PTR_W'(i))) begin
        entries[i] <= '{data: req_data_i, remaining: load_val};
      end else if (entries[i].remaining != '0) begin
        entries[i].remaining <= entries[i].remaining - CNT_WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   usage <= usage + USE_ONE;
        2'b01:   usage <= usage - USE_ONE;
        default: usage <= usage;
      endcase
    end
  end

endmodule
